// File: rtl/spectrum_x_mapper.sv
// spectrum_x_mapper: maps a display pixel column to an inclusive FFT bin range.
// A mapping table (one {lo, hi} entry per column) is built in hardware after
// reset and whenever the frequency-axis mode changes. Lookups are a fixed
// two-cycle pipeline: register the pixel, then read the table into the outputs.
module spectrum_x_mapper #(
   parameter int          H_ACTIVE    = 800,
   parameter int          N_BINS      = 512,
   parameter int          PIX_W       = $clog2(H_ACTIVE),
   parameter int          BIN_W       = $clog2(N_BINS),
   parameter int          FRAC_W      = 24,
   parameter int unsigned LOG_RATIO_Q =
      $rtoi(2.0 ** (real'(BIN_W) / real'(H_ACTIVE - 1) + real'(FRAC_W)) + 0.5)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode_log,
   input  logic [PIX_W-1:0] pixel_x,
   input  logic             active,
   output logic [BIN_W-1:0] bin_lo,
   output logic [BIN_W-1:0] bin_hi,
   output logic             bin_valid,
   output logic             busy
);

   localparam int ACC_W  = BIN_W + 1 + FRAC_W;
   localparam int IDX_W  = $clog2(H_ACTIVE + 1);
   localparam int STEP_Q = N_BINS / H_ACTIVE;
   localparam int STEP_R = N_BINS % H_ACTIVE;

   localparam logic [ACC_W-1:0] ACC_ONE = ACC_W'(1) << FRAC_W;
   localparam logic [ACC_W-1:0] RATIO   = ACC_W'(LOG_RATIO_Q);
   localparam logic [BIN_W-1:0] BIN_MAX = BIN_W'(N_BINS - 1);
   localparam logic [IDX_W-1:0] LAST_X  = IDX_W'(H_ACTIVE - 1);
   localparam logic [IDX_W-1:0] H_IDX   = IDX_W'(H_ACTIVE);

   typedef enum logic {BUILD, READY} state_t;

   // build-side state
   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               busy_q, busy_d;
   logic               build_mode_q, build_mode_d;
   logic               mode_q;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [BIN_W:0]     lq_q, lq_d;
   logic [PIX_W-1:0]   lr_q, lr_d;
   logic [BIN_W-1:0]   bprev_q, bprev_d;

   // generator datapath
   logic [2*ACC_W-1:0] prod;
   logic [ACC_W-1:0]   acc_nx;
   logic [BIN_W:0]     acc_int;
   logic [BIN_W-1:0]   b_log, b_lin, b_cur, b_hi;
   logic [PIX_W:0]     r_sum;
   logic [BIN_W:0]     lq_nx;
   logic [PIX_W-1:0]   lr_nx;
   logic               sel_log;

   // table write port
   logic               wr_en;
   logic [PIX_W-1:0]   wr_addr;
   logic [2*BIN_W-1:0] wr_data;
   logic [2*BIN_W-1:0] tbl_q [H_ACTIVE];

   // lookup pipeline
   logic [PIX_W-1:0]   px_q;
   logic               act_q;
   logic               lk_ok;
   logic [2*BIN_W-1:0] rd_ent;
   logic [BIN_W-1:0]   bin_lo_q, bin_lo_d, bin_hi_q, bin_hi_d;
   logic               bin_valid_q, bin_valid_d;

   // Both bin generators run side by side every build cycle; the latched mode
   // only picks which one feeds the table. Index 0 gives bin 0 in either mode,
   // so the mode can be sampled on that same cycle.
   always_comb begin
      prod    = {{ACC_W{1'b0}}, acc_q} * {{ACC_W{1'b0}}, RATIO};
      acc_nx  = ACC_W'(prod >> FRAC_W);
      acc_int = acc_q[ACC_W-1:FRAC_W];
      if (acc_int > (BIN_W+1)'(N_BINS)) b_log = BIN_MAX;
      else                              b_log = BIN_W'(acc_int - (BIN_W+1)'(1));
      if (idx_q == LAST_X) b_log = BIN_MAX;

      // incremental x*N_BINS/H_ACTIVE; remainder stays below H_ACTIVE so one
      // conditional subtract per step is enough
      b_lin = lq_q[BIN_W-1:0];
      r_sum = {1'b0, lr_q} + (PIX_W+1)'(STEP_R);
      if (r_sum >= (PIX_W+1)'(H_ACTIVE)) begin
         lr_nx = PIX_W'(r_sum - (PIX_W+1)'(H_ACTIVE));
         lq_nx = lq_q + (BIN_W+1)'(STEP_Q + 1);
      end else begin
         lr_nx = PIX_W'(r_sum);
         lq_nx = lq_q + (BIN_W+1)'(STEP_Q);
      end

      sel_log = (idx_q == '0) ? mode_log : build_mode_q;
      b_cur   = sel_log ? b_log : b_lin;
      // hi of the previous column reaches up to just below this column's bin
      b_hi    = (b_cur > bprev_q) ? b_cur - BIN_W'(1) : bprev_q;
   end

   // Next-state for the BUILD/READY controller and the build sequencer.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      busy_d       = busy_q;
      build_mode_d = build_mode_q;
      acc_d        = acc_q;
      lq_d         = lq_q;
      lr_d         = lr_q;
      bprev_d      = bprev_q;
      wr_en        = 1'b0;
      wr_addr      = '0;
      wr_data      = '0;
      case (state_q)
         BUILD: begin
            busy_d  = 1'b1;
            acc_d   = acc_nx;
            lq_d    = lq_nx;
            lr_d    = lr_nx;
            bprev_d = b_cur;
            if (idx_q == '0) build_mode_d = mode_log;
            if (idx_q != '0) begin
               wr_en   = 1'b1;
               wr_addr = PIX_W'(idx_q - IDX_W'(1));
               wr_data = (idx_q == H_IDX) ? {bprev_q, BIN_MAX} : {bprev_q, b_hi};
            end
            if (idx_q == H_IDX) begin
               state_d = READY;
               busy_d  = 1'b0;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         READY: begin
            if (mode_q != build_mode_q) begin
               state_d = BUILD;
               busy_d  = 1'b1;
               idx_d   = '0;
               acc_d   = ACC_ONE;
               lq_d    = '0;
               lr_d    = '0;
            end
         end
         default: state_d = BUILD;
      endcase
   end

   // Controller registers; reset restarts a full build from column 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= BUILD;
         idx_q        <= '0;
         busy_q       <= 1'b1;
         build_mode_q <= 1'b0;
         mode_q       <= 1'b0;
         acc_q        <= ACC_ONE;
         lq_q         <= '0;
         lr_q         <= '0;
         bprev_q      <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         busy_q       <= busy_d;
         build_mode_q <= build_mode_d;
         mode_q       <= mode_log;
         acc_q        <= acc_d;
         lq_q         <= lq_d;
         lr_q         <= lr_d;
         bprev_q      <= bprev_d;
      end
   end

   // Mapping table storage; contents are don't-care until a build finishes.
   always_ff @(posedge clk) begin
      if (wr_en) tbl_q[wr_addr] <= wr_data;
   end

   // Stage-2 lookup result; outputs are forced to zero when not valid.
   always_comb begin
      lk_ok       = act_q && (state_q == READY) && (IDX_W'(px_q) < H_IDX);
      rd_ent      = tbl_q[px_q];
      bin_valid_d = lk_ok;
      bin_lo_d    = lk_ok ? rd_ent[2*BIN_W-1:BIN_W] : '0;
      bin_hi_d    = lk_ok ? rd_ent[BIN_W-1:0]       : '0;
   end

   // Two-stage lookup pipeline: pixel/active register, then output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         px_q        <= '0;
         act_q       <= 1'b0;
         bin_lo_q    <= '0;
         bin_hi_q    <= '0;
         bin_valid_q <= 1'b0;
      end else begin
         px_q        <= pixel_x;
         act_q       <= active;
         bin_lo_q    <= bin_lo_d;
         bin_hi_q    <= bin_hi_d;
         bin_valid_q <= bin_valid_d;
      end
   end

   assign bin_lo    = bin_lo_q;
   assign bin_hi    = bin_hi_q;
   assign bin_valid = bin_valid_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_spectrum_x_mapper.sv
// Scoreboard bench for spectrum_x_mapper: the driver pushes expected
// {lo, hi} per looked-up pixel, a monitor pops on every bin_valid.
module tb_spectrum_x_mapper;
   localparam int H  = 800;
   localparam int N  = 512;
   localparam int PW = 10;
   localparam int BW = 9;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          mode_log = 1'b1;
   logic          active = 1'b0;
   logic [PW-1:0] pixel_x = '0;
   logic [BW-1:0] bin_lo, bin_hi;
   logic          bin_valid, busy;

   spectrum_x_mapper #(.H_ACTIVE(H), .N_BINS(N)) dut (
      .clk(clk), .rst(rst), .mode_log(mode_log), .pixel_x(pixel_x),
      .active(active), .bin_lo(bin_lo), .bin_hi(bin_hi),
      .bin_valid(bin_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct { int x; int lo; int hi; } exp_t;
   exp_t sbq[$];

   int checks = 0;
   int errors = 0;
   bit mon_en = 0;
   bit sb_ignore = 0;
   int log_lo[H], log_hi[H], lin_lo[H], lin_hi[H];

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // drive one pixel at the next falling edge; optionally queue its expectation
   task automatic drive(input int x, input bit act, input bit push, input int lo, input int hi);
      @(negedge clk);
      pixel_x = PW'(x);
      active  = act;
      if (push) sbq.push_back('{x, lo, hi});
   endtask

   // count falling edges (starting at the current one) while busy is high
   task automatic measure(input int flip_at, input int unflip_at, output int n);
      n = 0;
      while (busy && n < 3000) begin
         n++;
         if (n == flip_at || n == unflip_at) mode_log = ~mode_log;
         if (n == 700) active = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic wait_busy(input string nm);
      int w;
      w = 0;
      while (!busy && w < 20) begin
         w++;
         @(negedge clk);
      end
      check(nm, int'(busy), 1);
   endtask

   // monitor: compare every presented result against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en && !sb_ignore) begin
            if (bin_valid) begin
               checks++;
               if (sbq.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_valid: got lo=%0d hi=%0d with nothing expected", bin_lo, bin_hi);
               end else begin
                  e = sbq.pop_front();
                  if (int'(bin_lo) != e.lo || int'(bin_hi) != e.hi) begin
                     errors++;
                     $display("FAIL lookup x=%0d: got lo=%0d hi=%0d expected lo=%0d hi=%0d",
                              e.x, bin_lo, bin_hi, e.lo, e.hi);
                  end
               end
            end else if (bin_lo != '0 || bin_hi != '0) begin
               checks++;
               errors++;
               $display("FAIL zero_when_invalid: got lo=%0d hi=%0d expected 0/0", bin_lo, bin_hi);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      longint unsigned acc, ratio, ip;
      real r;
      int n, nb;

      // reference tables from the mapping definitions
      r = 2.0 ** (9.0 / 799.0 + 24.0);
      ratio = 64'($rtoi(r + 0.5));
      acc = 64'd1 << 24;
      for (int x = 0; x < H; x++) begin
         ip = acc >> 24;
         if (x == H - 1)         log_lo[x] = N - 1;
         else if (ip > 64'(N))   log_lo[x] = N - 1;
         else                    log_lo[x] = int'(ip) - 1;
         acc = (acc * ratio) >> 24;
         lin_lo[x] = (x * N) / H;
      end
      for (int x = 0; x < H - 1; x++) begin
         log_hi[x] = (log_lo[x+1] > log_lo[x]) ? log_lo[x+1] - 1 : log_lo[x];
         lin_hi[x] = (lin_lo[x+1] > lin_lo[x]) ? lin_lo[x+1] - 1 : lin_lo[x];
      end
      log_hi[H-1] = N - 1;
      lin_hi[H-1] = N - 1;

      // reset and initial log-mode build
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", int'(busy), 1);
      check("reset_valid", int'(bin_valid), 0);
      check("reset_lo", int'(bin_lo), 0);
      check("reset_hi", int'(bin_hi), 0);
      rst = 1'b0; mon_en = 1; active = 1'b1; pixel_x = PW'(5);
      measure(-1, -1, n);
      check("build_len_initial", n, 801);

      // log sweep plus hand checkpoints
      for (int x = 0; x < H; x++) drive(x, 1, 1, log_lo[x], log_hi[x]);
      drive(0, 1, 1, 0, 0);
      drive(88, 1, 1, 0, 0);
      drive(89, 1, 1, 1, 1);
      drive(798, 1, 1, log_lo[798], 510);
      drive(799, 1, 1, 511, 511);
      drive(850, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      check("out_of_range_valid", int'(bin_valid), 0);

      // switch to linear mid-line
      sb_ignore = 1;
      @(negedge clk); pixel_x = PW'(100); active = 1'b1; mode_log = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("busy_after_toggle", int'(busy), 1);
      @(negedge clk);
      check("valid_drop", int'(bin_valid), 0);
      measure(-1, -1, n);
      check("build_len_toggle", n + 1, 801);
      repeat (3) @(negedge clk);
      sb_ignore = 0;

      // linear sweep plus hand checkpoints
      for (int x = 0; x < H; x++) drive(x, 1, 1, lin_lo[x], lin_hi[x]);
      drive(0, 1, 1, 0, 0);
      drive(400, 1, 1, 256, 256);
      drive(799, 1, 1, 511, 511);
      repeat (3) drive(0, 0, 0, 0, 0);

      // flip mode away and back during a build: a single build results
      @(negedge clk); mode_log = 1'b1;
      wait_busy("flipback_start");
      measure(100, 200, n);
      check("build_len_flipback", n, 801);
      nb = 0;
      repeat (12) begin
         @(negedge clk);
         if (busy) nb++;
      end
      check("no_rebuild", nb, 0);
      drive(0, 1, 1, 0, 0);
      drive(89, 1, 1, 1, 1);
      drive(400, 1, 1, log_lo[400], log_hi[400]);
      drive(799, 1, 1, 511, 511);
      repeat (3) drive(0, 0, 0, 0, 0);

      // change mode and hold a flip during the build: a second build follows
      @(negedge clk); mode_log = 1'b0;
      wait_busy("hold_start");
      measure(100, -1, n);
      check("build_len_hold_first", n, 801);
      wait_busy("second_build");

      // asynchronous reset part-way through the build
      repeat (300) @(negedge clk);
      mode_log = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("rst_build_busy", int'(busy), 1);
      check("rst_build_valid", int'(bin_valid), 0);
      check("rst_build_lo", int'(bin_lo), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      measure(-1, -1, n);
      check("build_len_after_rst", n, 801);
      drive(400, 1, 1, 256, 256);
      repeat (3) drive(0, 0, 0, 0, 0);

      // asynchronous reset in the middle of a line with live outputs
      sb_ignore = 1;
      drive(700, 1, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      check("midline_valid", int'(bin_valid), 1);
      check("midline_lo", int'(bin_lo), 448);
      check("midline_hi", int'(bin_hi), 448);
      #1 rst = 1'b1;
      #1;
      check("rst_line_valid", int'(bin_valid), 0);
      check("rst_line_lo", int'(bin_lo), 0);
      check("rst_line_hi", int'(bin_hi), 0);
      check("rst_line_busy", int'(busy), 1);
      @(negedge clk);
      rst = 1'b0;
      measure(-1, -1, n);
      check("build_len_after_line_rst", n, 801);
      repeat (3) @(negedge clk);
      sb_ignore = 0;
      drive(400, 1, 1, 256, 256);
      drive(799, 1, 1, 511, 511);
      repeat (4) drive(0, 0, 0, 0, 0);
      check("sb_drained", sbq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
